// File: rtl/fp_pkg.sv
// Shared format definitions for the iterative FP multiplier: size decode, exponent
// rebasing constants, iteration counts and exponent limits.
package fp_pkg;

  typedef enum logic [1:0] {
    FmtSingle = 2'd0,
    FmtDouble = 2'd1,
    FmtQuad   = 2'd2
  } fmt_e;

  localparam logic [14:0] BiasQuad     = 15'd16383;
  localparam logic [14:0] RebaseDouble = 15'd15360;
  localparam logic [14:0] RebaseSingle = 15'd16256;

  localparam logic [6:0] IterSingle = 7'd24;
  localparam logic [6:0] IterDouble = 7'd53;
  localparam logic [6:0] IterQuad   = 7'd113;

  localparam logic [14:0] ExpMaxSingle = 15'd255;
  localparam logic [14:0] ExpMaxDouble = 15'd2047;
  localparam logic [14:0] ExpMaxQuad   = 15'd32767;

  // Quad wins over double, double over single; bit1 is don't-care.
  function automatic fmt_e decode_fmt(input logic [2:0] code);
    if (code[2]) return FmtQuad;
    if (code[0]) return FmtDouble;
    return FmtSingle;
  endfunction

  function automatic logic [6:0] iter_count(input fmt_e fmt);
    case (fmt)
      FmtDouble: return IterDouble;
      FmtQuad:   return IterQuad;
      default:   return IterSingle;
    endcase
  endfunction

  function automatic logic [14:0] exp_rebase(input fmt_e fmt);
    case (fmt)
      FmtDouble: return RebaseDouble;
      FmtQuad:   return 15'd0;
      default:   return RebaseSingle;
    endcase
  endfunction

  function automatic logic [14:0] exp_max(input fmt_e fmt);
    case (fmt)
      FmtDouble: return ExpMaxDouble;
      FmtQuad:   return ExpMaxQuad;
      default:   return ExpMaxSingle;
    endcase
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits one operand into sign, exponent rebased to bias 16383, left-aligned
// 113-bit significand and NaN/Inf/Zero class flags. Denormals read as zero.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [127:0] op_i,
  input  fmt_e         fmt_i,
  output logic         sign_o,
  output logic [14:0]  exp_o,
  output logic [112:0] sig_o,
  output logic         nan_o,
  output logic         inf_o,
  output logic         zero_o
);

  logic [14:0]  e_raw;
  logic [111:0] f_raw;
  logic         e_ones;

  always_comb begin
    sign_o = op_i[31];
    e_raw  = {7'b0, op_i[30:23]};
    f_raw  = {op_i[22:0], 89'b0};
    e_ones = &op_i[30:23];
    case (fmt_i)
      FmtDouble: begin
        sign_o = op_i[63];
        e_raw  = {4'b0, op_i[62:52]};
        f_raw  = {op_i[51:0], 60'b0};
        e_ones = &op_i[62:52];
      end
      FmtQuad: begin
        sign_o = op_i[127];
        e_raw  = op_i[126:112];
        f_raw  = op_i[111:0];
        e_ones = &op_i[126:112];
      end
      default: ;
    endcase
    zero_o = (e_raw == 15'd0);
    inf_o  = e_ones && (f_raw == '0);
    nan_o  = e_ones && (f_raw != '0);
    exp_o  = e_raw + exp_rebase(fmt_i);
    sig_o  = {1'b1, f_raw};
  end

endmodule

// File: rtl/fpmul_iter128.sv
// Iterative radix-2 shift-add floating-point multiplier for single/double/quad
// operands, one multiplier bit per cycle, truncating normalisation.
module fpmul_iter128
  import fp_pkg::*;
#(
  parameter int unsigned DSTWidth = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ACT,
  input  logic                CMD,
  input  logic [2:0]          SA,
  input  logic [2:0]          SB,
  input  logic [127:0]        A,
  input  logic [127:0]        B,
  input  logic [DSTWidth-1:0] DSTi,
  output logic [127:0]        R,
  output logic [DSTWidth-1:0] DSTo,
  output logic [2:0]          SR,
  output logic                RDY,
  output logic                Zero,
  output logic                Sign,
  output logic                Inf,
  output logic                NaN,
  output logic                NEXT
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StIter = 3'd1;
  localparam logic [2:0] StNorm = 3'd2;
  localparam logic [2:0] StPack = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  fmt_e         fmt_a, fmt_b;
  logic         a_sign, a_nan, a_inf, a_zero, b_sign, b_nan, b_inf, b_zero;
  logic [14:0]  a_exp, b_exp;
  logic [112:0] a_sig, b_sig;

  assign fmt_a = decode_fmt(SA);
  assign fmt_b = decode_fmt(SB);

  fp_unpack u_unpack_a (
    .op_i   (A),
    .fmt_i  (fmt_a),
    .sign_o (a_sign),
    .exp_o  (a_exp),
    .sig_o  (a_sig),
    .nan_o  (a_nan),
    .inf_o  (a_inf),
    .zero_o (a_zero)
  );

  fp_unpack u_unpack_b (
    .op_i   (B),
    .fmt_i  (fmt_b),
    .sign_o (b_sign),
    .exp_o  (b_exp),
    .sig_o  (b_sig),
    .nan_o  (b_nan),
    .inf_o  (b_inf),
    .zero_o (b_zero)
  );

  logic [2:0]          state_q;
  logic [6:0]          cnt_q, lim_q, cnt_nxt;
  fmt_e                fmt_q;
  logic [2:0]          sr_q;
  logic [DSTWidth-1:0] dst_q;
  logic                sign_q, nan_a_q, inf_a_q, zero_a_q, nan_b_q, inf_b_q, zero_b_q;
  logic [14:0]         exp_a_q, exp_b_q, eres_q;
  logic [112:0]        sig_a_q, mpl_q, hi_q;
  logic                lo_q, ovf_q, unf_q;
  logic [111:0]        frac_q;
  logic [127:0]        res_q;
  logic                res_zero_q, res_inf_q, res_nan_q;

  logic         special, carry, res_nan, res_inf, res_zero;
  logic [113:0] sum;
  logic [16:0]  e_calc;
  logic [14:0]  exp_f;
  logic [111:0] frac_f;
  logic [127:0] packed_res;

  assign NEXT    = (state_q == StIdle);
  assign special = nan_a_q | inf_a_q | zero_a_q | nan_b_q | inf_b_q | zero_b_q;

  always_comb begin
    sum     = {1'b0, hi_q} + (mpl_q[0] ? {1'b0, sig_a_q} : 114'd0);
    cnt_nxt = (special && (cnt_q == 7'd1)) ? lim_q : cnt_q + 7'd1;
    carry   = hi_q[112];
    // Two's-complement in 17 bits, expressed directly in the result format's bias.
    e_calc  = {2'b0, exp_a_q} + {2'b0, exp_b_q} + {16'b0, carry}
            - {2'b0, BiasQuad} - {2'b0, exp_rebase(fmt_q)};
    res_nan  = nan_a_q | nan_b_q | (inf_a_q & zero_b_q) | (zero_a_q & inf_b_q);
    res_inf  = !res_nan && (inf_a_q | inf_b_q | (!special && ovf_q));
    res_zero = !res_nan && !res_inf && (zero_a_q | zero_b_q | (!special && unf_q));
    exp_f  = eres_q;
    frac_f = frac_q;
    if (res_nan) begin
      exp_f  = '1;
      frac_f = '1;
    end else if (res_inf) begin
      exp_f  = '1;
      frac_f = '0;
    end else if (res_zero) begin
      exp_f  = '0;
      frac_f = '0;
    end
    case (fmt_q)
      FmtDouble: packed_res = {64'b0, sign_q, exp_f[10:0], frac_f[111:60]};
      FmtQuad:   packed_res = {sign_q, exp_f, frac_f};
      default:   packed_res = {96'b0, sign_q, exp_f[7:0], frac_f[111:89]};
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      lim_q    <= '0;
      fmt_q    <= FmtSingle;
      sr_q     <= '0;
      dst_q    <= '0;
      sign_q   <= 1'b0;
      nan_a_q  <= 1'b0;
      inf_a_q  <= 1'b0;
      zero_a_q <= 1'b0;
      nan_b_q  <= 1'b0;
      inf_b_q  <= 1'b0;
      zero_b_q <= 1'b0;
      exp_a_q  <= '0;
      exp_b_q  <= '0;
      eres_q   <= '0;
      sig_a_q  <= '0;
      mpl_q    <= '0;
      hi_q     <= '0;
      lo_q     <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      frac_q   <= '0;
      res_q    <= '0;
      res_zero_q <= 1'b0;
      res_inf_q  <= 1'b0;
      res_nan_q  <= 1'b0;
      R    <= '0;
      DSTo <= '0;
      SR   <= '0;
      RDY  <= 1'b0;
      Zero <= 1'b0;
      Sign <= 1'b0;
      Inf  <= 1'b0;
      NaN  <= 1'b0;
    end else begin
      RDY <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ACT) begin
            // Square reuses B as both operands; A and SA play no part.
            fmt_q    <= CMD ? fmt_b : fmt_a;
            sr_q     <= CMD ? SB : SA;
            dst_q    <= DSTi;
            sign_q   <= CMD ? 1'b0 : (a_sign ^ b_sign);
            exp_a_q  <= CMD ? b_exp : a_exp;
            exp_b_q  <= b_exp;
            sig_a_q  <= CMD ? b_sig : a_sig;
            nan_a_q  <= CMD ? b_nan : a_nan;
            inf_a_q  <= CMD ? b_inf : a_inf;
            zero_a_q <= CMD ? b_zero : a_zero;
            nan_b_q  <= b_nan;
            inf_b_q  <= b_inf;
            zero_b_q <= b_zero;
            lim_q    <= iter_count(fmt_b);
            mpl_q    <= b_sig >> (7'd113 - iter_count(fmt_b));
            hi_q     <= '0;
            lo_q     <= 1'b0;
            cnt_q    <= '0;
            state_q  <= StIter;
          end
        end
        StIter: begin
          hi_q  <= sum[113:1];
          lo_q  <= sum[0];
          mpl_q <= mpl_q >> 1;
          cnt_q <= cnt_nxt;
          if (cnt_nxt == lim_q) state_q <= StNorm;
        end
        StNorm: begin
          frac_q  <= carry ? hi_q[111:0] : {hi_q[110:0], lo_q};
          eres_q  <= e_calc[14:0];
          ovf_q   <= !e_calc[16] && (e_calc >= {2'b0, exp_max(fmt_q)});
          unf_q   <= e_calc[16] || (e_calc == 17'd0);
          state_q <= StPack;
        end
        StPack: begin
          res_q      <= packed_res;
          res_zero_q <= res_zero;
          res_inf_q  <= res_inf;
          res_nan_q  <= res_nan;
          state_q    <= StDone;
        end
        StDone: begin
          R       <= res_q;
          DSTo    <= dst_q;
          SR      <= sr_q;
          Zero    <= res_zero_q;
          Sign    <= sign_q;
          Inf     <= res_inf_q;
          NaN     <= res_nan_q;
          RDY     <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/fpmul_iter128.md
FPMUL_ITER128 -- requirements
Module: fpmul_iter128

Interface
REQ-001 Parameter DSTWidth, default 4: width of the destination tag carried from DSTi to DSTo.
REQ-002 CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 RST  input  1  reset, asynchronous and active-low.
REQ-004 ACT  input  1  start request, sampled only while NEXT=1.
REQ-005 CMD  input  1  operation select: 0 = multiply A*B; 1 = square B*B (A, SA ignored).
REQ-006 SA, SB  input  3  operand size codes: bit2=1 quad (1/15/112); else bit0=1 double (1/11/52); else single (1/8/23).
REQ-007 A, B  input  128  operands, right-aligned in their size; upper bits ignored.
REQ-008 DSTi  input  DSTWidth  destination tag, captured on accept.
REQ-009 R  output  128  result in size SR, right-aligned; unused upper bits 0.
REQ-010 DSTo  output  DSTWidth  tag of the operation whose result is on R.
REQ-011 SR  output  3  result size code, equal to CMD ? SB : SA of the accepted request.
REQ-012 RDY  output  1  one-cycle pulse: R, DSTo, SR and flags valid.
REQ-013 Zero, Sign, Inf, NaN  output  1 each  result classification flags, valid with RDY.
REQ-014 NEXT  output  1  idle indicator, ~busy; 1 = a new request can be accepted.

Function
REQ-015 Accept: ACT=1 and NEXT=1 at a rising edge starts an operation and registers the unpacked operands, CMD, size and DSTi; NEXT goes to 0 on that edge.
REQ-016 ACT while NEXT=0 shall be ignored, with no effect on the operation in flight.
REQ-017 Unpack: exponents rebased to 15-bit bias 16383 (single +16256, double +15360, quad unchanged); significand = {1, fraction} left-aligned to 113 bits; exponent 0 with fraction ≠ 0 is flushed to zero.
REQ-018 Datapath: radix-2 shift-add, one multiplier bit per cycle; iteration count N = 24 single, 53 double, 113 quad.
REQ-019 Latency: RDY shall be high exactly N+3 rising edges after the accept edge (27 single, 56 double, 116 quad) for normal operands.
REQ-020 Early exit: if either operand is NaN, Inf or zero, the iteration counter jumps to its limit on the second iteration, and RDY shall be high 5 edges after accept.
REQ-021 Normalize: if the product MSB is set, take the upper fraction bits and add 1 to the exponent; otherwise shift left by one; truncate with no rounding.
REQ-022 Exponent: E = EA + EB − 16383 + carry, computed 17 bits wide with sign; biased result ≥ format maximum → overflow; ≤ 0 → underflow.
REQ-023 Sign: SignA ^ SignB for multiply; 0 for square.
REQ-024 Priority NaN > Inf > Zero > normal:
- NaN: either operand NaN, or Inf×0 → exponent all ones, fraction all ones, NaN=1.
- Inf: either operand Inf, or overflow → exponent all ones, fraction 0, Inf=1.
- Zero: either operand zero, or underflow → exponent 0, fraction 0, Zero=1.
REQ-025 Completion: NEXT returns to 1 on the same edge RDY is registered high, so an ACT in the RDY cycle is accepted back-to-back.
REQ-026 DSTo, SR and R shall hold their values until the next RDY.

Reset
REQ-027 RST=0 shall immediately clear: busy (NEXT=1), RDY, Zero, Sign, Inf, NaN, R, DSTo, SR, the counter and the iteration registers.
REQ-028 Reset during an operation aborts it; no RDY is produced for the aborted operation, and after release the next ACT behaves as from idle.

Structure
REQ-029 Shared package fp_pkg holds: the size-code enum, bias constants (16383, 15360, 16256), per-format iteration counts, and per-format exponent limits.
REQ-030 One sub-module, fp_unpack, is instantiated for each operand and produces sign, rebased exponent, significand and the NaN/Inf/Zero flags.

Verification
REQ-031 Single multiply: A=0x3FC00000, B=0x40000000, CMD=0 → R=0x40400000, RDY exactly 27 edges after accept.
REQ-032 Double square: CMD=1, B=0x4008000000000000 → R=0x4022000000000000, SR=3'b001, RDY at 56 edges, Sign=0.
REQ-033 Quad special case: A=+Inf, B=+0 → NaN=1, R[126:112]=all ones, fraction all ones; RDY at 5 edges.
REQ-034 Single overflow: A=B=0x7F000000 → R=0x7F800000, Inf=1.
REQ-035 Busy and reset handling:
- ACT pulsed mid-operation with DSTi=5 → ignored; DSTo keeps the original tag.
- RST=0 asserted mid-operation → outputs cleared asynchronously; no RDY; a fresh request afterwards completes correctly.
